// File: rtl/ip_table_access_ctrl_pkg.sv
// Shared constants and types for the destination-IP table access controller.
// Register map indices are byte offsets divided by four (address bits [4:2]).
package ip_table_access_ctrl_pkg;

  localparam logic [2:0] REG_WR_DATA = 3'd0;
  localparam logic [2:0] REG_ADDR    = 3'd1;
  localparam logic [2:0] REG_CMD     = 3'd2;
  localparam logic [2:0] REG_RD_DATA = 3'd3;
  localparam logic [2:0] REG_STATUS  = 3'd4;
  localparam logic [2:0] REG_WR_OPS  = 3'd5;
  localparam logic [2:0] REG_RD_OPS  = 3'd6;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_TIMEOUT = 2;
  localparam int ST_CMD_ERR = 3;

  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    WR_REQ,
    RD_REQ,
    WAIT_ACK
  } state_t;

endpackage

// File: rtl/ip_table_access_ctrl_axi_lite_reg_if.sv
// AXI4-Lite slave handshakes for the table access controller.
// Turns bus transfers into register strobes; response codes come from the top.
module ip_table_access_ctrl_axi_lite_reg_if
  import ip_table_access_ctrl_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] awaddr,
  input  logic          awvalid,
  output logic          awready,
  input  logic [DW-1:0] wdata,
  input  logic          wvalid,
  output logic          wready,
  output logic [1:0]    bresp,
  output logic          bvalid,
  input  logic          bready,
  input  logic [AW-1:0] araddr,
  input  logic          arvalid,
  output logic          arready,
  output logic [DW-1:0] rdata,
  output logic [1:0]    rresp,
  output logic          rvalid,
  input  logic          rready,
  output logic          wr_strobe,
  output logic [2:0]    wr_offset,
  output logic [DW-1:0] wr_data,
  input  logic [1:0]    wr_resp,
  output logic          rd_strobe,
  output logic [2:0]    rd_offset,
  input  logic [DW-1:0] rd_data
);

  logic          aw_rdy;
  logic          ar_rdy;
  logic          b_vld;
  logic          r_vld;
  logic [1:0]    b_resp;
  logic [DW-1:0] r_data;
  logic          unused_bits;

  assign wr_strobe = aw_rdy & awvalid & wvalid;
  assign wr_offset = awaddr[4:2];
  assign wr_data   = wdata;
  assign rd_strobe = ar_rdy & arvalid;
  assign rd_offset = araddr[4:2];

  assign awready = aw_rdy;
  assign wready  = aw_rdy;
  assign arready = ar_rdy;
  assign bvalid  = b_vld;
  assign bresp   = b_resp;
  assign rvalid  = r_vld;
  assign rdata   = r_data;
  assign rresp   = RESP_OKAY;

  assign unused_bits = ^{awaddr[AW-1:5], awaddr[1:0],
                         araddr[AW-1:5], araddr[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_rdy <= 1'b0;
      b_vld  <= 1'b0;
      b_resp <= RESP_OKAY;
    end else begin
      // ready is a one-cycle pulse so each address/data pair lands once
      aw_rdy <= awvalid & wvalid & ~b_vld & ~aw_rdy;
      if (wr_strobe) begin
        b_vld  <= 1'b1;
        b_resp <= wr_resp;
      end else if (bready) begin
        b_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_rdy <= 1'b0;
      r_vld  <= 1'b0;
      r_data <= '0;
    end else begin
      ar_rdy <= arvalid & ~r_vld & ~ar_rdy;
      if (rd_strobe) begin
        r_vld  <= 1'b1;
        r_data <= rd_data;
      end else if (rready) begin
        r_vld <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ip_table_access_ctrl.sv
// Host-side requester for the 32-entry destination-IP table port.
// Optional ack timeout compiled in with IP_TBL_ACK_TIMEOUT_EN.
module ip_table_access_ctrl
  import ip_table_access_ctrl_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_TBL_ADDR_WIDTH   = 5,
  parameter int C_ACK_TIMEOUT      = 16
) (
  input  logic                            AXI_ACLK,
  input  logic                            AXI_RESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            tbl_wr_req,
  output logic                            tbl_rd_req,
  output logic [C_TBL_ADDR_WIDTH-1:0]     tbl_wr_addr,
  output logic [C_TBL_ADDR_WIDTH-1:0]     tbl_rd_addr,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   tbl_wr_data,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   tbl_rd_data,
  input  logic                            tbl_wr_ack,
  input  logic                            tbl_rd_ack
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int TW = C_TBL_ADDR_WIDTH;
  localparam logic [7:0] ACK_LIMIT = 8'(C_ACK_TIMEOUT);

  state_t        state;
  state_t        state_nx;
  logic          reg_wr;
  logic [2:0]    wr_offset;
  logic [DW-1:0] reg_wdata;
  logic [1:0]    wr_resp;
  logic          rd_strobe;
  logic [2:0]    rd_offset;
  logic [DW-1:0] rd_word;
  logic [DW-1:0] status;

  logic [DW-1:0] wr_data_r;
  logic [TW-1:0] addr_r;
  logic [DW-1:0] rd_data_r;
  logic [DW-1:0] wr_ops;
  logic [DW-1:0] rd_ops;
  logic          done_r;
  logic          cmd_err_r;
  logic          timeout_r;
  logic          op_rd;
  logic [TW-1:0] tbl_addr_q;
  logic [DW-1:0] tbl_data_q;

  logic busy;
  logic cmd_wr;
  logic cmd_ok;
  logic start_wr;
  logic start_rd;
  logic ack_hit;
  logic timeout_hit;
  logic unused_bits;

  ip_table_access_ctrl_axi_lite_reg_if #(
    .DW (DW),
    .AW (C_S_AXI_ADDR_WIDTH)
  ) u_axi_lite_reg_if (
    .clk       (AXI_ACLK),
    .rst_n     (AXI_RESETN),
    .awaddr    (S_AXI_AWADDR),
    .awvalid   (S_AXI_AWVALID),
    .awready   (S_AXI_AWREADY),
    .wdata     (S_AXI_WDATA),
    .wvalid    (S_AXI_WVALID),
    .wready    (S_AXI_WREADY),
    .bresp     (S_AXI_BRESP),
    .bvalid    (S_AXI_BVALID),
    .bready    (S_AXI_BREADY),
    .araddr    (S_AXI_ARADDR),
    .arvalid   (S_AXI_ARVALID),
    .arready   (S_AXI_ARREADY),
    .rdata     (S_AXI_RDATA),
    .rresp     (S_AXI_RRESP),
    .rvalid    (S_AXI_RVALID),
    .rready    (S_AXI_RREADY),
    .wr_strobe (reg_wr),
    .wr_offset (wr_offset),
    .wr_data   (reg_wdata),
    .wr_resp   (wr_resp),
    .rd_strobe (rd_strobe),
    .rd_offset (rd_offset),
    .rd_data   (rd_word)
  );

  assign unused_bits = ^{S_AXI_WSTRB, rd_strobe};

  assign busy     = (state != IDLE);
  assign cmd_wr   = reg_wr && (wr_offset == REG_CMD);
  assign cmd_ok   = cmd_wr && !busy;
  assign start_wr = cmd_ok && (reg_wdata[1:0] == CMD_WRITE);
  assign start_rd = cmd_ok && (reg_wdata[1:0] == CMD_READ);
  assign wr_resp  = (cmd_wr && busy) ? RESP_SLVERR : RESP_OKAY;
  assign ack_hit  = (state == WAIT_ACK) &&
                    (op_rd ? tbl_rd_ack : tbl_wr_ack);

  assign tbl_wr_req  = (state == WR_REQ);
  assign tbl_rd_req  = (state == RD_REQ);
  assign tbl_wr_addr = tbl_addr_q;
  assign tbl_rd_addr = tbl_addr_q;
  assign tbl_wr_data = tbl_data_q;

`ifdef IP_TBL_ACK_TIMEOUT_EN
  logic [7:0] timer;

  // timer counts WAIT_ACK cycles; the last allowed cycle still accepts an ack
  assign timeout_hit = (state == WAIT_ACK) && !ack_hit &&
                       (timer == ACK_LIMIT - 8'd1);

  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      timer     <= 8'd0;
      timeout_r <= 1'b0;
    end else begin
      if (state == WAIT_ACK) timer <= timer + 8'd1;
      else                   timer <= 8'd0;
      if (cmd_ok)           timeout_r <= 1'b0;
      else if (timeout_hit) timeout_r <= 1'b1;
    end
  end
`else
  logic [7:0] unused_limit;

  assign unused_limit = ACK_LIMIT;
  assign timeout_hit  = 1'b0;
  assign timeout_r    = 1'b0;
`endif

  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) state <= IDLE;
    else             state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start_wr)      state_nx = WR_REQ;
        else if (start_rd) state_nx = RD_REQ;
      end
      WR_REQ:   state_nx = WAIT_ACK;
      RD_REQ:   state_nx = WAIT_ACK;
      WAIT_ACK: if (ack_hit || timeout_hit) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      wr_data_r  <= '0;
      addr_r     <= '0;
      rd_data_r  <= '0;
      wr_ops     <= '0;
      rd_ops     <= '0;
      done_r     <= 1'b0;
      cmd_err_r  <= 1'b0;
      op_rd      <= 1'b0;
      tbl_addr_q <= '0;
      tbl_data_q <= '0;
    end else begin
      if (reg_wr && wr_offset == REG_WR_DATA) wr_data_r <= reg_wdata;
      if (reg_wr && wr_offset == REG_ADDR)    addr_r    <= reg_wdata[TW-1:0];
      if (cmd_ok) begin
        done_r    <= 1'b0;
        cmd_err_r <= !(start_wr || start_rd);
        op_rd     <= start_rd;
      end
      // table outputs freeze here so later host writes can't disturb them
      if (start_wr || start_rd) tbl_addr_q <= addr_r;
      if (start_wr)             tbl_data_q <= wr_data_r;
      if (ack_hit) begin
        done_r <= 1'b1;
        if (op_rd) begin
          rd_data_r <= tbl_rd_data;
          rd_ops    <= rd_ops + DW'(1);
        end else begin
          wr_ops <= wr_ops + DW'(1);
        end
      end
    end
  end

  always_comb begin
    status             = '0;
    status[ST_BUSY]    = busy;
    status[ST_DONE]    = done_r;
    status[ST_TIMEOUT] = timeout_r;
    status[ST_CMD_ERR] = cmd_err_r;
  end

  always_comb begin
    rd_word = '0;
    case (rd_offset)
      REG_WR_DATA: rd_word = wr_data_r;
      REG_ADDR:    rd_word = DW'(addr_r);
      REG_RD_DATA: rd_word = rd_data_r;
      REG_STATUS:  rd_word = status;
      REG_WR_OPS:  rd_word = wr_ops;
      REG_RD_OPS:  rd_word = rd_ops;
      default:     rd_word = '0;
    endcase
  end

endmodule
